// File: rtl/rom_arb_pkg.sv
// Shared definitions for the two-port ROM arbiter: default geometry,
// burst limit and the ownership state encoding.
package rom_arb_pkg;

  localparam int ROM_ADDR_W    = 13;
  localparam int ROM_DATA_W    = 8;
  localparam int ROM_BURST_MAX = 4;

  // ARB: round-robin between ports; OWNn: port n holds a locked burst.
  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bundle of the ROM arbiter: two read ports.
//
// Handshake: reqN is level-sensitive and sampled combinationally. gntN is a
// one-cycle pulse in the cycle addrN is issued to the ROM. There is no
// backpressure on the return path: rd_validN pulses exactly one cycle after
// gntN, and rd_dataN holds the returned byte until the next rd_validN.
interface rom_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
);

  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              lock0;
  logic              lock1;
  logic              gnt0;
  logic              gnt1;
  logic              rd_valid0;
  logic              rd_valid1;
  logic [DATA_W-1:0] rd_data0;
  logic [DATA_W-1:0] rd_data1;

  modport master (
    output req0, req1, addr0, addr1, lock0, lock1,
    input  gnt0, gnt1, rd_valid0, rd_valid1, rd_data0, rd_data1
  );

  modport slave (
    input  req0, req1, addr0, addr1, lock0, lock1,
    output gnt0, gnt1, rd_valid0, rd_valid1, rd_data0, rd_data1
  );

endinterface

// File: rtl/rom_arb_rr.sv
// Two-way round-robin picker. When both ports request, ptr selects the
// winner; a sole requester always wins. Output is one-hot or zero.
module rom_arb_rr (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Pick one requester, favouring the port named by ptr on a tie.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a shared synchronous ROM. Grants one port per
// cycle (round-robin, or a bounded locked burst), issues its address to the
// ROM combinationally and returns the registered ROM byte one cycle later.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W    = ROM_ADDR_W,
  parameter int DATA_W    = ROM_DATA_W,
  parameter int BURST_MAX = ROM_BURST_MAX
) (
  input  logic              clk,
  input  logic              reset_n,
  rom_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] rom_a,
  output logic              rom_ce,
  output logic              rom_oe,
  input  logic [DATA_W-1:0] rom_d,
  output arb_state_t        state_dbg
);

  localparam int              CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  logic              rst_meta;
  logic              run;
  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              ptr;
  logic              ptr_nxt;
  logic [1:0]        rr_gnt;
  logic              own_keep;
  logic              gnt0;
  logic              gnt1;
  logic [ADDR_W-1:0] last_a;
  logic              vld0;
  logic              vld1;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;

  // Reset release is synchronized; grants are enabled once run is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta <= 1'b0;
      run      <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      run      <= rst_meta;
    end
  end

  rom_arb_rr u_rr (
    .req ({bus.req1, bus.req0}),
    .ptr (ptr),
    .gnt (rr_gnt)
  );

  // Next-state and grant decode: keep a locked owner, otherwise round-robin.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    own_keep  = 1'b0;

    // Ownership ends when the owner lets go or its burst is spent while
    // the other port is waiting; a spent burst alone does not end it.
    case (state)
      OWN0:    own_keep = bus.req0 && bus.lock0 && !((cnt == CNT_MAX) && bus.req1);
      OWN1:    own_keep = bus.req1 && bus.lock1 && !((cnt == CNT_MAX) && bus.req0);
      default: own_keep = 1'b0;
    endcase

    if (!run) begin
      state_nxt = ARB;
      cnt_nxt   = '0;
    end else if (own_keep) begin
      if (state == OWN0) begin
        gnt0    = 1'b1;
        ptr_nxt = 1'b1;
      end else begin
        gnt1    = 1'b1;
        ptr_nxt = 1'b0;
      end
      if (cnt != CNT_MAX) begin
        cnt_nxt = cnt + 1'b1;
      end
    end else begin
      // Leaving ownership arbitrates in the same cycle, so the waiting
      // port (favoured by ptr) is granted without a bubble.
      gnt0      = rr_gnt[0];
      gnt1      = rr_gnt[1];
      state_nxt = ARB;
      cnt_nxt   = '0;
      if (rr_gnt[0]) begin
        ptr_nxt = 1'b1;
        if (bus.lock0) begin
          state_nxt = OWN0;
          cnt_nxt   = CNT_W'(1);
        end
      end else if (rr_gnt[1]) begin
        ptr_nxt = 1'b0;
        if (bus.lock1) begin
          state_nxt = OWN1;
          cnt_nxt   = CNT_W'(1);
        end
      end
    end
  end

  // Arbitration state, burst count and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB;
      cnt   <= '0;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // ROM address follows the granted port and holds its value otherwise.
  always_comb begin
    rom_a = last_a;
    if (gnt0) begin
      rom_a = bus.addr0;
    end else if (gnt1) begin
      rom_a = bus.addr1;
    end
  end

  // Return path: remember the issued port, capture the byte it gets back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_a <= '0;
      vld0   <= 1'b0;
      vld1   <= 1'b0;
      hold0  <= '0;
      hold1  <= '0;
    end else begin
      last_a <= rom_a;
      vld0   <= gnt0;
      vld1   <= gnt1;
      if (vld0) hold0 <= rom_d;
      if (vld1) hold1 <= rom_d;
    end
  end

  assign rom_ce        = gnt0 | gnt1;
  assign rom_oe        = gnt0 | gnt1;
  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rd_valid0 = vld0;
  assign bus.rd_valid1 = vld1;
  // ROM output is already registered, so it is forwarded in the valid cycle.
  assign bus.rd_data0  = vld0 ? rom_d : hold0;
  assign bus.rd_data1  = vld1 ? rom_d : hold1;
  assign state_dbg     = state;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed vector table, locked-burst
// and reset sequences, then a randomized run against a ROM model.
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int BM = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] rom_a;
  logic          rom_ce;
  logic          rom_oe;
  logic [DW-1:0] rom_d = '0;
  arb_state_t    state_dbg;

  rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .rom_a     (rom_a),
    .rom_ce    (rom_ce),
    .rom_oe    (rom_oe),
    .rom_d     (rom_d),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / ROM model ----------------
  always #5 clk = ~clk;

  logic [DW-1:0] mem [8192];

  always @(posedge clk) begin
    if (rom_ce) rom_d <= mem[rom_a];
  end

  // ---------------- scoreboard state ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic          pg0, pg1;
  logic [AW-1:0] pa0, pa1, last_a;
  logic [DW-1:0] held0, held1;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];

  typedef struct {
    logic          r0, r1, l0, l1;
    logic [AW-1:0] a0, a1;
    logic          g0, g1, v0, v1;
    arb_state_t    st;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic r0, r1, l0, l1,
                              input logic [AW-1:0] a0, a1,
                              input logic g0, g1, v0, v1,
                              input arb_state_t st);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
    v.a0 = a0; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    v.st = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: inputs change 1ns after the rising edge, outputs are
  // sampled 6ns after it (just past the falling edge).
  task automatic drive(input logic r0, r1, l0, l1, input logic [AW-1:0] a0, a1);
    @(posedge clk);
    #1;
    bus.req0 = r0; bus.req1 = r1;
    bus.lock0 = l0; bus.lock1 = l1;
    bus.addr0 = a0; bus.addr1 = a1;
    #5;
  endtask

  task automatic clear_model();
    pg0 = 1'b0; pg1 = 1'b0;
    pa0 = '0; pa1 = '0;
    last_a = '0;
    held0 = '0; held1 = '0;
  endtask

  // Compare one sampled cycle against expected grants/valids.
  task automatic check_cycle(input string tag, input logic eg0, eg1, ev0, ev1);
    logic [AW-1:0] ea;
    chk($sformatf("%s.gnt0", tag), bus.gnt0, eg0);
    chk($sformatf("%s.gnt1", tag), bus.gnt1, eg1);
    chk($sformatf("%s.rom_ce", tag), rom_ce, eg0 | eg1);
    chk($sformatf("%s.rom_oe", tag), rom_oe, eg0 | eg1);
    ea = eg0 ? bus.addr0 : (eg1 ? bus.addr1 : last_a);
    chk($sformatf("%s.rom_a", tag), rom_a, ea);
    chk($sformatf("%s.rd_valid0", tag), bus.rd_valid0, ev0);
    chk($sformatf("%s.rd_valid1", tag), bus.rd_valid1, ev1);
    if (ev0) held0 = mem[pa0];
    if (ev1) held1 = mem[pa1];
    chk($sformatf("%s.rd_data0", tag), bus.rd_data0, held0);
    chk($sformatf("%s.rd_data1", tag), bus.rd_data1, held1);
    last_a = ea;
    pa0 = bus.addr0; pa1 = bus.addr1;
    pg0 = eg0; pg1 = eg1;
  endtask

  task automatic release_reset(input string tag, input logic r0, r1, input logic [AW-1:0] a0, a1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.req0 = r0; bus.req1 = r1; bus.addr0 = a0; bus.addr1 = a1;
    #5;
    check_cycle($sformatf("%s.c0", tag), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(r0, r1, 1'b0, 1'b0, a0, a1);
    check_cycle($sformatf("%s.c1", tag), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- test ----------------
  logic          r0, r1, l0, l1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] e;
  int            w0, w1;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'hA5;

    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.lock0 = 1'b0; bus.lock1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0;
    clear_model();

    // Reset state, then synchronized release.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 13'h0010, 13'h0020);
    check_cycle("init_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("init_rst.state", state_dbg, ARB);
    release_reset("init", 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    check_cycle("init.c2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Directed table: r0 r1 l0 l1 a0 a1 | g0 g1 v0 v1 state
    vecs[0]  = mk(1,0,0,0, 13'h0010, 13'h0000, 1,0,0,0, ARB);
    vecs[1]  = mk(0,0,0,0, 13'h0000, 13'h0000, 0,0,1,0, ARB);
    vecs[2]  = mk(1,1,0,0, 13'h0100, 13'h0200, 0,1,0,0, ARB);
    vecs[3]  = mk(1,1,0,0, 13'h0101, 13'h0201, 1,0,0,1, ARB);
    vecs[4]  = mk(1,1,0,0, 13'h0102, 13'h0202, 0,1,1,0, ARB);
    vecs[5]  = mk(1,1,0,0, 13'h0103, 13'h0203, 1,0,0,1, ARB);
    vecs[6]  = mk(0,0,0,0, 13'h0000, 13'h0000, 0,0,1,0, ARB);
    vecs[7]  = mk(0,1,0,0, 13'h0000, 13'h1FFF, 0,1,0,0, ARB);
    vecs[8]  = mk(1,0,0,0, 13'h0000, 13'h0000, 1,0,0,1, ARB);
    vecs[9]  = mk(0,1,0,1, 13'h0000, 13'h0300, 0,1,1,0, ARB);
    vecs[10] = mk(0,1,0,1, 13'h0000, 13'h0301, 0,1,0,1, OWN1);
    vecs[11] = mk(1,1,0,1, 13'h0040, 13'h0302, 0,1,0,1, OWN1);
    vecs[12] = mk(1,1,0,1, 13'h0041, 13'h0303, 0,1,0,1, OWN1);
    vecs[13] = mk(1,1,0,1, 13'h0050, 13'h0304, 1,0,0,1, OWN1);
    vecs[14] = mk(1,1,0,1, 13'h0051, 13'h0305, 0,1,1,0, ARB);
    vecs[15] = mk(0,1,0,1, 13'h0000, 13'h0306, 0,1,0,1, OWN1);
    vecs[16] = mk(1,1,0,0, 13'h0052, 13'h0307, 1,0,0,1, OWN1);
    vecs[17] = mk(1,1,1,0, 13'h0053, 13'h0308, 0,1,1,0, ARB);
    vecs[18] = mk(0,0,0,0, 13'h0000, 13'h0000, 0,0,0,1, ARB);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].l0, vecs[i].l1, vecs[i].a0, vecs[i].a1);
      check_cycle($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].v0, vecs[i].v1);
      chk($sformatf("vec%0d.state", i), state_dbg, vecs[i].st);
    end

    // Locked burst on port 0 with port 1 waiting: 0,0,0,0,1,0.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, AW'(13'h0400 + k), AW'(13'h0600 + k));
      check_cycle($sformatf("burst0.%0d", k), (k != 4), (k == 4), pg0, pg1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    check_cycle("burst0.drop", 1'b0, 1'b0, pg0, pg1);
    chk("burst0.drop.state", state_dbg, OWN0);

    // Port 1 locked alone for 10 cycles; saturated count ends on port 0 request.
    for (int k = 0; k < 11; k++) begin
      drive((k == 10), 1'b1, 1'b0, 1'b1, 13'h00AA, AW'(13'h0700 + k));
      check_cycle($sformatf("own1.%0d", k), (k == 10), (k != 10), pg0, pg1);
      if (k > 0) chk($sformatf("own1.%0d.state", k), state_dbg, OWN1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    check_cycle("own1.end", 1'b0, 1'b0, pg0, pg1);
    chk("own1.end.state", state_dbg, ARB);

    // Reset in the cycle after a grant: the read is dropped.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 13'h0010, '0);
    check_cycle("rst.gnt", 1'b1, 1'b0, pg0, pg1);
    reset_n = 1'b0;
    #1;
    chk("rst.async.gnt0", bus.gnt0, 1'b0);
    chk("rst.async.rom_ce", rom_ce, 1'b0);
    chk("rst.async.rom_a", rom_a, '0);
    chk("rst.async.rd_valid0", bus.rd_valid0, 1'b0);
    clear_model();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 13'h0010, '0);
      check_cycle($sformatf("rst.hold%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("rst.hold%0d.state", k), state_dbg, ARB);
    end
    release_reset("rst", 1'b1, 1'b1, 13'h0020, 13'h0030);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 13'h0020, 13'h0030);
    check_cycle("rst.c2", 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    check_cycle("rst.c3", 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the ROM model.
    w0 = 0; w1 = 0;
    for (int c = 0; c < 10000; c++) begin
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      l0 = ($urandom_range(0, 2) == 0);
      l1 = ($urandom_range(0, 2) == 0);
      a0 = AW'($urandom_range(0, 8191));
      a1 = AW'($urandom_range(0, 8191));
      drive(r0, r1, l0, l1, a0, a1);
      if (bus.rd_valid0) begin
        if (exp_q0.size() == 0) chk("rnd.spurious_valid0", 1'b1, 1'b0);
        else begin
          e = exp_q0.pop_front();
          chk("rnd.rd_data0", bus.rd_data0, e);
        end
      end
      if (bus.rd_valid1) begin
        if (exp_q1.size() == 0) chk("rnd.spurious_valid1", 1'b1, 1'b0);
        else begin
          e = exp_q1.pop_front();
          chk("rnd.rd_data1", bus.rd_data1, e);
        end
      end
      chk("rnd.double_gnt", bus.gnt0 & bus.gnt1, 1'b0);
      if (bus.gnt0) begin
        chk("rnd.gnt0_req", r0, 1'b1);
        chk("rnd.rom_a0", rom_a, a0);
        exp_q0.push_back(mem[a0]);
      end
      if (bus.gnt1) begin
        chk("rnd.gnt1_req", r1, 1'b1);
        chk("rnd.rom_a1", rom_a, a1);
        exp_q1.push_back(mem[a1]);
      end
      chk("rnd.q0_pending", (exp_q0.size() > 1), 1'b0);
      chk("rnd.q1_pending", (exp_q1.size() > 1), 1'b0);
      w0 = (r0 && !bus.gnt0) ? w0 + 1 : 0;
      w1 = (r1 && !bus.gnt1) ? w1 + 1 : 0;
      chk("rnd.wait0", (w0 > BM + 1), 1'b0);
      chk("rnd.wait1", (w1 > BM + 1), 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    if (bus.rd_valid0 && exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      chk("rnd.tail0", bus.rd_data0, e);
    end
    if (bus.rd_valid1 && exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      chk("rnd.tail1", bus.rd_data1, e);
    end
    chk("rnd.drain0", exp_q0.size(), 0);
    chk("rnd.drain1", exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, 13, ROM address width (8192 locations).
REQ-002 Parameter DATA_W, 8, ROM data width.
REQ-003 Parameter BURST_MAX, 4, max consecutive grants to a locked port while the other port waits.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req0 / req1  in  1  read request from port 0 (CPU fetch) / port 1 (video/test fetch), level-sensitive.
REQ-007 addr0 / addr1  in  ADDR_W  read address, valid while the matching req is high.
REQ-008 lock0 / lock1  in  1  burst request; keeps ownership while req stays high.
REQ-009 gnt0 / gnt1  out  1  one-cycle pulse; the port's address is issued to the ROM this cycle.
REQ-010 rd_valid0 / rd_valid1  out  1  one-cycle pulse; rd_data of that port is valid.
REQ-011 rd_data0 / rd_data1  out  DATA_W  returned ROM byte, held until the next rd_valid of that port.
REQ-012 rom_a  out  ADDR_W  address to the shared ROM.
REQ-013 rom_ce / rom_oe  out  1  ROM enables, high in issue cycles only.
REQ-014 rom_d  in  DATA_W  ROM output, registered by the ROM, valid one cycle after issue.

Function
REQ-015 The block SHALL grant at most one port per cycle; gnt0 and gnt1 never both high.
REQ-016 In a grant cycle the block SHALL drive rom_a combinationally from the granted port's addr and assert rom_ce and rom_oe.
REQ-017 In non-grant cycles the block SHALL hold rom_a at its last value and deassert rom_ce/rom_oe.
REQ-018 Exactly one cycle after gntN the block SHALL pulse rd_validN and load rd_dataN from rom_d (issue-to-data latency 1 cycle).
REQ-019 Back-to-back grants SHALL be supported; throughput one read per cycle.
REQ-020 Sole requester: granted in the same cycle req is sampled high.
REQ-021 Both requesting, no lock: round-robin; grant goes to the port not granted last; pointer updates on every grant.
REQ-022 FSM states ARB (round-robin), OWN0, OWN1.
REQ-023 ARB -> OWNn when port n is granted with lockn high.
REQ-024 OWNn: port n granted every cycle reqn is high; burst counter increments per grant.
REQ-025 OWNn -> ARB when reqn drops, lockn drops, or the counter reaches BURST_MAX while the other port requests; the other port SHALL then be granted next cycle.
REQ-026 Counter reaching BURST_MAX with no competing request SHALL NOT end ownership; counter saturates at BURST_MAX.
REQ-027 Burst counter SHALL clear on entry to ARB.
REQ-028 A request dropped in the same cycle it would be granted is not granted (req sampled combinationally).
REQ-029 Address change on the granted port between grants SHALL be honored per grant; no address caching.

Reset
REQ-030 While reset_n is low: gnt*, rd_valid*, rom_ce, rom_oe = 0; rd_data* = 0; rom_a = 0; state ARB; RR pointer favors port 0; burst counter 0.
REQ-031 A read issued in the cycle before reset asserts SHALL produce no rd_valid after reset.
REQ-032 Reset deassertion SHALL be synchronized internally; the first grant is possible in the second cycle after deassertion.

Structure
REQ-033 ADDR_W/DATA_W defaults, BURST_MAX, and the state enum SHALL live in shared package rom_arb_pkg.
REQ-034 The two-way round-robin picker SHALL be sub-module rom_arb_rr (req pair, pointer in; one-hot grant out).
REQ-035 The ROM itself is external; rom_arbiter contains no storage beyond rd_data registers.

Verification
REQ-036 req0 only, addr0=0x0010, ROM[0x0010]=0xA5 -> gnt0 cycle T, rom_a=0x0010, rd_valid0 at T+1 with rd_data0=0xA5.
REQ-037 req0 and req1 held high, no lock -> grants alternate 0,1,0,1...; each rd_validN exactly 1 cycle after gntN.
REQ-038 lock0+req0 held, req1 high from start, BURST_MAX=4 -> four gnt0, then gnt1, then round-robin resumes.
REQ-039 lock1+req1 held, req0 low -> gnt1 every cycle for 10 cycles; state stays OWN1.
REQ-040 reset_n low the cycle after gnt0 -> no rd_valid0; all outputs 0; after release the first grant goes to port 0 when both request.
REQ-041 Random req/addr for 10000 cycles vs. a reference ROM model -> every rd_data matches, no double grant, no request waits more than BURST_MAX+1 cycles.
